// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: clears an up/down counter, seeks lo_lim, then runs
// N triangle sweeps lo_lim->hi_lim->lo_lim. Optional limit dwell: SWEEP_DWELL_EN.
module counter_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int SWP_W = 4
`ifdef SWEEP_DWELL_EN
  ,
  parameter int DWELL_CYC = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] lo_lim,
  input  logic [WIDTH-1:0] hi_lim,
  input  logic [SWP_W-1:0] sweeps,
  input  logic [WIDTH-1:0] ctr_in,
  output logic             ctr_rst,
  output logic             ctr_enable,
  output logic             ctr_direction,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic [SWP_W-1:0] sweep_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SEEK,
    S_UP,
    S_DOWN,
    S_DWELL,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [SWP_W-1:0] r_swp;
  logic [SWP_W-1:0] r_swp_cnt;
  logic             r_err;

  logic             w_cfg_ok;
  logic             w_at_lo;
  logic             w_at_hi;
  logic             w_at_zero;
  logic [SWP_W-1:0] w_swp_nxt;

`ifdef SWEEP_DWELL_EN
  localparam int DW_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  logic [DW_W-1:0] r_dwell;
  logic            r_dwl_dn;
`endif

  assign w_cfg_ok  = (lo_lim < hi_lim) && (sweeps != '0);
  assign w_at_lo   = (ctr_in == r_lo);
  assign w_at_hi   = (ctr_in == r_hi);
  assign w_at_zero = (ctr_in == '0);
  assign w_swp_nxt = r_swp_cnt + SWP_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lo      <= '0;
      r_hi      <= '0;
      r_swp     <= '0;
      r_swp_cnt <= '0;
      r_err     <= 1'b0;
`ifdef SWEEP_DWELL_EN
      r_dwell   <= '0;
      r_dwl_dn  <= 1'b0;
`endif
    end else begin
      r_err <= 1'b0;
      // stop overrides every transition, sweep_cnt keeps its value
      if (stop && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_cfg_ok) begin
                r_lo      <= lo_lim;
                r_hi      <= hi_lim;
                r_swp     <= sweeps;
                r_swp_cnt <= '0;
                r_state   <= S_CLR;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_CLR: begin
            if (w_at_zero) r_state <= S_SEEK;
          end
          S_SEEK: begin
            if (w_at_lo) r_state <= S_UP;
          end
          S_UP: begin
            if (w_at_hi) begin
`ifdef SWEEP_DWELL_EN
              r_dwell  <= DW_W'(DWELL_CYC - 1);
              r_dwl_dn <= 1'b1;
              r_state  <= S_DWELL;
`else
              r_state  <= S_DOWN;
`endif
            end
          end
          S_DOWN: begin
            if (w_at_lo) begin
              r_swp_cnt <= w_swp_nxt;
              if (w_swp_nxt == r_swp) begin
                r_state <= S_DONE;
              end else begin
`ifdef SWEEP_DWELL_EN
                r_dwell  <= DW_W'(DWELL_CYC - 1);
                r_dwl_dn <= 1'b0;
                r_state  <= S_DWELL;
`else
                r_state  <= S_UP;
`endif
              end
            end
          end
`ifdef SWEEP_DWELL_EN
          S_DWELL: begin
            if (r_dwell == '0) begin
              r_state <= r_dwl_dn ? S_DOWN : S_UP;
            end else begin
              r_dwell <= r_dwell - DW_W'(1);
            end
          end
`endif
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // counter controls decode from state plus the live counter value
  always_comb begin
    ctr_rst       = rst;
    ctr_enable    = 1'b0;
    ctr_direction = 1'b0;
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    unique case (r_state)
      S_CLR: ctr_rst = 1'b1;
      S_SEEK: begin
        ctr_direction = 1'b1;
        ctr_enable    = ~w_at_lo;
      end
      S_UP: begin
        ctr_direction = 1'b1;
        ctr_enable    = ~w_at_hi;
      end
      S_DOWN: ctr_enable = ~w_at_lo;
`ifdef SWEEP_DWELL_EN
      S_DWELL: ctr_direction = r_dwl_dn;
`endif
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign err_cfg   = r_err;
  assign sweep_cnt = r_swp_cnt;

endmodule
